layer_fx_scheduler: RTL

Per-frame display-effect sequencer that sits ahead of the VGA object priority mux. It decides, once per video frame, which drawing layers may reach the mux (player, monster, shields, player missile, monster missile, lifebar) and when a full-screen colour override is applied. It sequences the game's visual effects: player-hit blink, monster-kill flash, and game-over layer-by-layer fade. All visible outputs change only on the start-of-frame strobe, so the screen never tears mid-frame.

---
 rtl/layer_fx_scheduler.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/layer_fx_scheduler.sv
// Per-frame display-effect sequencer ahead of the VGA priority mux.
// Gates drawing layers and applies colour overrides on frame boundaries.
module layer_fx_scheduler #(
  parameter int HIT_FRAMES = 60,
  parameter int BLINK_HALF = 8,
  parameter int FLASH_FRAMES = 4,
  parameter int FADE_STEP = 8,
  parameter logic [7:0] FLASH_RGB = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       gameStart,
  input  logic       playerHit,
  input  logic       monsterKilled,
  input  logic       gameOver,
  output logic [5:0] layerEnable,
  output logic       overrideEn,
  output logic [7:0] overrideRGB,
  output logic [2:0] fxState
);

  localparam int M0 = (HIT_FRAMES > BLINK_HALF)
                    ? HIT_FRAMES : BLINK_HALF;
  localparam int M1 = (FLASH_FRAMES > FADE_STEP)
                    ? FLASH_FRAMES : FADE_STEP;
  localparam int MAXP = (M0 > M1) ? M0 : M1;
  localparam int CW = $clog2(MAXP) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_HIT   = 3'd2;
  localparam logic [2:0] S_FLASH = 3'd3;
  localparam logic [2:0] S_FADE  = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  logic [2:0]    state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [CW-1:0] bcnt, nbcnt;
  logic          phase, nphase;
  logic [2:0]    step, nstep;
  logic [5:0]    omask;
  logic          oov;
  logic          ev;
  logic          go_hit, go_flash, go_fade;

  // removal order: bit4, bit3, bit1, bit2, bit0
  function automatic logic [5:0] fade_mask(input logic [2:0] s);
    case (s)
      3'd0:    fade_mask = 6'h2F;
      3'd1:    fade_mask = 6'h27;
      3'd2:    fade_mask = 6'h25;
      3'd3:    fade_mask = 6'h21;
      default: fade_mask = 6'h20;
    endcase
  endfunction

  always_comb begin
    nstate   = state;
    ncnt     = cnt;
    nbcnt    = bcnt;
    nphase   = phase;
    nstep    = step;
    omask    = 6'h00;
    oov      = 1'b0;
    go_hit   = 1'b0;
    go_flash = 1'b0;
    go_fade  = 1'b0;
    ev       = 1'b0;

    case (state)
      S_PLAY:  omask = 6'h3F;
      S_HIT:   omask = {5'h1F, phase};
      S_FLASH: begin
        omask = 6'h3F;
        oov   = 1'b1;
      end
      S_FADE:  omask = fade_mask(step);
      S_OVER:  omask = 6'h20;
      default: omask = 6'h00;
    endcase

    case (state)
      S_IDLE, S_OVER: begin
        if (gameStart) begin
          nstate = S_PLAY;
          ev     = 1'b1;
        end
      end
      S_PLAY: begin
        if (gameOver)           go_fade  = 1'b1;
        else if (playerHit)     go_hit   = 1'b1;
        else if (monsterKilled) go_flash = 1'b1;
      end
      S_HIT: begin
        if (gameOver)       go_fade = 1'b1;
        else if (playerHit) go_hit  = 1'b1;
      end
      S_FLASH: begin
        if (gameOver)           go_fade  = 1'b1;
        else if (playerHit)     go_hit   = 1'b1;
        else if (monsterKilled) go_flash = 1'b1;
      end
      default: ;
    endcase

    if (go_hit) begin
      nstate = S_HIT;
      ncnt   = CW'(HIT_FRAMES);
      nbcnt  = '0;
      nphase = 1'b0;
      ev     = 1'b1;
    end
    if (go_flash) begin
      nstate = S_FLASH;
      ncnt   = CW'(FLASH_FRAMES);
      ev     = 1'b1;
    end
    if (go_fade) begin
      nstate = S_FADE;
      ncnt   = CW'(FADE_STEP - 1);
      nstep  = 3'd0;
      ev     = 1'b1;
    end

    // frame-driven progress only when no event claimed this cycle
    if (!ev && startOfFrame) begin
      case (state)
        S_HIT: begin
          if (cnt == '0) begin
            nstate = S_PLAY;
            omask  = 6'h3F;
          end else begin
            ncnt = cnt - 1'b1;
            if (bcnt == CW'(BLINK_HALF - 1)) begin
              nbcnt  = '0;
              nphase = ~phase;
            end else begin
              nbcnt = bcnt + 1'b1;
            end
          end
        end
        S_FLASH: begin
          if (cnt == '0) begin
            nstate = S_PLAY;
            omask  = 6'h3F;
            oov    = 1'b0;
          end else begin
            ncnt = cnt - 1'b1;
          end
        end
        S_FADE: begin
          if (step == 3'd5) begin
            nstate = S_OVER;
            omask  = 6'h20;
          end else if (cnt == '0) begin
            ncnt  = CW'(FADE_STEP - 1);
            nstep = step + 3'd1;
          end else begin
            ncnt = cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bcnt        <= '0;
      phase       <= 1'b0;
      step        <= 3'd0;
      layerEnable <= 6'h00;
      overrideEn  <= 1'b0;
      overrideRGB <= 8'h00;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      bcnt  <= nbcnt;
      phase <= nphase;
      step  <= nstep;
      if (startOfFrame) begin
        layerEnable <= omask;
        overrideEn  <= oov;
        overrideRGB <= oov ? FLASH_RGB : 8'h00;
      end
    end
  end

  assign fxState = state;

endmodule
